// File: rtl/mp3dec_seq_ctrl.sv
// rtl/mp3dec_seq_ctrl.sv - MP3 decode run-control sequencer (FIFO/decoder reset, prefill gate, interrupts).
// Optional starvation detection, STARVE state and underrun counter: define MP3DEC_SEQ_STARVE_EN.
module mp3dec_seq_ctrl #(
  parameter int RD_CNT_W   = 10,
  parameter int PREFILL    = 256,
  parameter int RST_CYCLES = 8
`ifdef MP3DEC_SEQ_STARVE_EN
  ,
  parameter int STARVE_CYCLES = 4096,
  parameter int STARVE_W      = 13
`endif
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_flush,
  input  logic [RD_CNT_W-1:0] fifo_rd_count,
  input  logic                fifo_rst_busy,
  input  logic                dec_fifo_empty,
  input  logic                dec_invalid,
  input  logic                intr_clr,
  output logic                fifo_rst,
  output logic                dec_rst,
  output logic                dec_en,
  output logic [2:0]          state,
  output logic [1:0]          intr_cause,
  output logic                intr,
  output logic [15:0]         underrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_PREFILL   = 3'd3,
    S_RUN       = 3'd4,
    S_STARVE    = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RST_CNT_W-1:0]   r_rst_cnt;
  logic                   r_fifo_rst;
  logic                   r_dec_rst;
  logic                   r_dec_en;
  logic [1:0]             r_intr_cause;
  logic                   r_intr;
  logic                   w_rst_restart;
  logic                   w_set_starve;
  logic                   w_set_fmt;
  logic                   w_starve_hit;
  logic                   w_prefill_ok;
  logic [1:0]             w_cause_nxt;
  logic                   w_fifo_rst_nxt;
  logic                   w_dec_rst_nxt;
  logic                   w_dec_en_nxt;

  assign w_prefill_ok = (fifo_rd_count >= RD_CNT_W'(PREFILL));

`ifdef MP3DEC_SEQ_STARVE_EN
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [15:0]         r_underrun_cnt;

  assign w_starve_hit = dec_fifo_empty && (r_starve_cnt == STARVE_W'(STARVE_CYCLES - 1));

  // Counter only runs while staying in RUN, so every entry to RUN starts from zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_starve_cnt   <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (r_state == S_RUN && w_state_nxt == S_RUN && dec_fifo_empty)
        r_starve_cnt <= r_starve_cnt + 1'b1;
      else
        r_starve_cnt <= '0;
      if (w_set_starve && r_underrun_cnt != 16'hFFFF)
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  logic w_unused_empty;
  assign w_unused_empty = &{1'b0, dec_fifo_empty};
  assign w_starve_hit   = 1'b0;
  assign underrun_cnt   = 16'h0000;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_restart = 1'b0;
    w_set_starve  = 1'b0;
    w_set_fmt     = 1'b0;
    if (cmd_stop) begin
      w_state_nxt = S_IDLE;
    end else if ((cmd_flush && r_state != S_IDLE) ||
                 (cmd_start && (r_state == S_IDLE || r_state == S_ERROR))) begin
      w_state_nxt   = S_RESET;
      w_rst_restart = 1'b1;
    end else begin
      case (r_state)
        S_RESET:     if (r_rst_cnt == RST_LAST) w_state_nxt = S_WAIT_BUSY;
        S_WAIT_BUSY: if (!fifo_rst_busy) w_state_nxt = S_PREFILL;
        S_PREFILL:   if (w_prefill_ok) w_state_nxt = S_RUN;
        S_RUN: begin
          if (dec_invalid) begin
            w_state_nxt = S_ERROR;
            w_set_fmt   = 1'b1;
          end else if (w_starve_hit) begin
            w_state_nxt  = S_STARVE;
            w_set_starve = 1'b1;
          end
        end
        S_STARVE:    if (w_prefill_ok) w_state_nxt = S_RUN;
        default:     ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_fifo_rst_nxt = 1'b0;
    w_dec_rst_nxt  = 1'b0;
    w_dec_en_nxt   = 1'b0;
    case (w_state_nxt)
      S_IDLE:      w_dec_rst_nxt = 1'b1;
      S_RESET: begin
        w_fifo_rst_nxt = 1'b1;
        w_dec_rst_nxt  = 1'b1;
      end
      S_WAIT_BUSY: w_dec_rst_nxt = 1'b1;
      S_RUN:       w_dec_en_nxt  = 1'b1;
      S_ERROR:     w_dec_rst_nxt = 1'b1;
      default:     ;
    endcase
  end

  assign w_cause_nxt = (intr_clr ? 2'b00 : r_intr_cause) | {w_set_fmt, w_set_starve};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_fifo_rst   <= 1'b0;
      r_dec_rst    <= 1'b1;
      r_dec_en     <= 1'b0;
      r_intr_cause <= 2'b00;
      r_intr       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_RESET && !w_rst_restart)
        r_rst_cnt <= r_rst_cnt + 1'b1;
      else
        r_rst_cnt <= '0;
      r_fifo_rst   <= w_fifo_rst_nxt;
      r_dec_rst    <= w_dec_rst_nxt;
      r_dec_en     <= w_dec_en_nxt;
      r_intr_cause <= w_cause_nxt;
      r_intr       <= |w_cause_nxt;
    end
  end

  assign state      = r_state;
  assign fifo_rst   = r_fifo_rst;
  assign dec_rst    = r_dec_rst;
  assign dec_en     = r_dec_en;
  assign intr_cause = r_intr_cause;
  assign intr       = r_intr;

endmodule

// File: tb/tb_mp3dec_seq_ctrl.sv
// tb/tb_mp3dec_seq_ctrl.sv - directed plus randomized bench for mp3dec_seq_ctrl against a behavioural model.
module tb_mp3dec_seq_ctrl;
  localparam int PREFILL       = 256;
  localparam int RST_CYCLES    = 8;
  localparam int STARVE_CYCLES = 4096;
`ifdef MP3DEC_SEQ_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  localparam int IDLE = 0, RESET = 1, WAITB = 2, PREF = 3, RUN = 4, STARVE = 5, ERR = 6;

  logic        Clk, Rst;
  logic        cmd_start, cmd_stop, cmd_flush;
  logic [9:0]  fifo_rd_count;
  logic        fifo_rst_busy, dec_fifo_empty, dec_invalid, intr_clr;
  logic        fifo_rst, dec_rst, dec_en, intr;
  logic [2:0]  state;
  logic [1:0]  intr_cause;
  logic [15:0] underrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mp3dec_seq_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_flush(cmd_flush),
    .fifo_rd_count(fifo_rd_count), .fifo_rst_busy(fifo_rst_busy),
    .dec_fifo_empty(dec_fifo_empty), .dec_invalid(dec_invalid), .intr_clr(intr_clr),
    .fifo_rst(fifo_rst), .dec_rst(dec_rst), .dec_en(dec_en), .state(state),
    .intr_cause(intr_cause), .intr(intr), .underrun_cnt(underrun_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: mode number, remaining reset cycles, length of current empty run.
  int       m_state, m_reset_left, m_empty_run, m_under;
  logic [1:0] m_cause;

  task automatic model_reset();
    m_state = IDLE; m_reset_left = 0; m_empty_run = 0; m_under = 0; m_cause = 2'b00;
  endtask

  task automatic model_step();
    int  nxt;
    bit  s0, s1;
    nxt = m_state; s0 = 0; s1 = 0;
    if (cmd_stop) nxt = IDLE;
    else if ((cmd_flush && m_state != IDLE) || (cmd_start && (m_state == IDLE || m_state == ERR))) begin
      nxt = RESET; m_reset_left = RST_CYCLES;
    end else if (m_state == RESET) begin
      m_reset_left--;
      if (m_reset_left == 0) nxt = WAITB;
    end else if (m_state == WAITB) begin
      if (!fifo_rst_busy) nxt = PREF;
    end else if (m_state == PREF || m_state == STARVE) begin
      if (int'(fifo_rd_count) >= PREFILL) nxt = RUN;
    end else if (m_state == RUN) begin
      if (dec_invalid) begin nxt = ERR; s1 = 1; end
      else if (STARVE_EN) begin
        m_empty_run = dec_fifo_empty ? m_empty_run + 1 : 0;
        if (m_empty_run == STARVE_CYCLES) begin nxt = STARVE; s0 = 1; end
      end
    end
    if (nxt != RUN) m_empty_run = 0;
    if (intr_clr) m_cause = 2'b00;
    m_cause = m_cause | {s1, s0};
    if (s0 && m_under < 65535) m_under++;
    m_state = nxt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("fifo_rst", 32'(fifo_rst), 32'(m_state == RESET));
    check("dec_rst", 32'(dec_rst), 32'(m_state inside {IDLE, RESET, WAITB, ERR}));
    check("dec_en", 32'(dec_en), 32'(m_state == RUN));
    check("intr_cause", 32'(intr_cause), 32'(m_cause));
    check("intr", 32'(intr), 32'(m_cause != 2'b00));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_all();
    cmd_start = 0; cmd_stop = 0; cmd_flush = 0; intr_clr = 0; dec_invalid = 0;
  endtask

  task automatic bring_to_run();
    fifo_rst_busy = 0; fifo_rd_count = 10'd300; dec_fifo_empty = 0;
    cmd_start = 1;
    repeat (13) tick();
    check("run_reached", 32'(state), RUN);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, w;
    Rst = 1; cmd_start = 0; cmd_stop = 0; cmd_flush = 0; fifo_rd_count = '0;
    fifo_rst_busy = 0; dec_fifo_empty = 0; dec_invalid = 0; intr_clr = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 check_all();
    @(negedge Clk) Rst = 0;

    cmd_flush = 1; tick();
    check("flush_idle", 32'(state), IDLE);

    n = 0; w = 0; cmd_start = 1;
    for (int k = 0; k < 14; k++) begin
      fifo_rst_busy = (k < 13);
      tick();
      if (fifo_rst) n++;
      if (state == 3'(WAITB)) w++;
    end
    check("bringup_fifo_rst_cycles", 32'(n), 8);
    check("bringup_wait_cycles", 32'(w), 5);
    check("bringup_prefill", 32'(state), PREF);
    for (int v = 0; v <= 304; v += 16) begin
      fifo_rd_count = 10'(v);
      tick();
      if (v == 240) check("en_before_256", 32'(dec_en), 0);
      if (v == 256) check("en_at_256", 32'(dec_en), 1);
    end

    dec_fifo_empty = 1;
    repeat (STARVE_CYCLES - 1) tick();
    dec_invalid = 1; tick();
    dec_fifo_empty = 0;
    check("err_state", 32'(state), ERR);
    check("err_cause", 32'(intr_cause), 2);
    check("err_underrun", 32'(underrun_cnt), 0);
    check("err_dec_rst", 32'(dec_rst), 1);
    intr_clr = 1; tick();
    check("err_clr_intr", 32'(intr), 0);
    cmd_start = 1; tick();
    check("err_restart", 32'(state), RESET);

    n = 1;
    repeat (4) begin tick(); if (fifo_rst) n++; end
    cmd_flush = 1;
    fifo_rst_busy = 0; fifo_rd_count = 10'd300;
    repeat (13) begin tick(); if (fifo_rst) n++; end
    check("flush_reset_cycles", 32'(n), 13);
    check("flush_to_run", 32'(state), RUN);

    cmd_stop = 1; cmd_flush = 1; tick();
    check("stop_flush_idle", 32'(state), IDLE);
    check("stop_dec_rst", 32'(dec_rst), 1);

`ifdef MP3DEC_SEQ_STARVE_EN
    bring_to_run();
    fifo_rd_count = 10'd0; dec_fifo_empty = 1;
    repeat (STARVE_CYCLES - 1) tick();
    dec_fifo_empty = 0; tick();
    check("no_starve_4095", 32'(state), RUN);
    dec_fifo_empty = 1;
    repeat (STARVE_CYCLES) tick();
    dec_fifo_empty = 0;
    check("starve_state", 32'(state), STARVE);
    check("starve_intr", 32'(intr), 1);
    check("starve_underrun", 32'(underrun_cnt), 1);
    fifo_rd_count = 10'd256; tick();
    check("starve_resume", 32'(dec_en), 1);
    intr_clr = 1; tick();
    dec_fifo_empty = 1;
    repeat (STARVE_CYCLES - 1) tick();
    intr_clr = 1; tick();
    dec_fifo_empty = 0;
    check("race_cause0", 32'(intr_cause[0]), 1);
    check("race_underrun", 32'(underrun_cnt), 2);
    tick();
    intr_clr = 1; tick();
    check("race_clear", 32'(intr), 0);
    cmd_stop = 1; tick();
`endif

    bring_to_run();
    @(posedge Clk);
    #3 Rst = 1;
    #1 model_reset();
    check_all();
    check("async_dec_en", 32'(dec_en), 0);
    #1 Rst = 0;
    repeat (5) tick();
    check("async_stays_idle", 32'(state), IDLE);

    for (int i = 0; i < 3000; i++) begin
      cmd_start      = ($urandom_range(0, 15) == 0);
      cmd_stop       = ($urandom_range(0, 63) == 0);
      cmd_flush      = ($urandom_range(0, 47) == 0);
      fifo_rst_busy  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       fifo_rd_count = 10'd255;
        1:       fifo_rd_count = 10'd256;
        default: fifo_rd_count = 10'($urandom_range(0, 1023));
      endcase
      dec_fifo_empty = ($urandom_range(0, 3) != 0);
      dec_invalid    = ($urandom_range(0, 99) == 0);
      intr_clr       = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mp3dec_seq_ctrl.md
# mp3dec_seq_ctrl

Run-control sequencer for the MP3 decode path, in the MP3DEC_CLK domain between the AHB register front end and the `Mp3Decode` core plus its input FIFO. It takes start/stop/flush commands and sequences the input-FIFO reset, the decoder reset and enable, and the prefill gate. It also detects input starvation and invalid-format errors and raises a sticky interrupt.

## Interface
- `RD_CNT_W`, 10: width of the input-FIFO read-side fill count.
- `PREFILL`, 256: minimum fill level in words before the decoder is enabled or resumed. Must be < 2^RD_CNT_W.
- `RST_CYCLES`, 8: number of cycles `fifo_rst` is held high. Must be ≥ 1.
- `STARVE_CYCLES`, 4096: consecutive empty cycles in RUN that declare starvation. Must be ≥ 2.
- `STARVE_W`, 13: width of the starvation counter. Must satisfy 2^STARVE_W > STARVE_CYCLES.

Ports:
- `Clk`  in  1  MP3DEC clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `cmd_start`  in  1  single-cycle start pulse.
- `cmd_stop`  in  1  single-cycle stop pulse.
- `cmd_flush`  in  1  single-cycle flush/restart pulse.
- `fifo_rd_count`  in  RD_CNT_W  input-FIFO fill level (read side).
- `fifo_rst_busy`  in  1  OR of the FIFO wr/rd reset-busy flags, already synchronized to `Clk`.
- `dec_fifo_empty`  in  1  empty indication as presented to the decoder.
- `dec_invalid`  in  1  decoder `Invalid_format`.
- `intr_clr`  in  1  clears both interrupt cause bits.
- `fifo_rst`  out  1  input-FIFO reset.
- `dec_rst`  out  1  decoder reset, active-high.
- `dec_en`  out  1  decoder enable.
- `state`  out  3  current state code.
- `intr_cause`  out  2  sticky causes: bit0 = starvation, bit1 = format error.
- `intr`  out  1  equals `|intr_cause`.
- `underrun_cnt`  out  16  count of starvation events; saturates at 0xFFFF.

## Operation
All outputs are registered and decoded from the state.

- **IDLE (0):** `dec_rst`=1, `dec_en`=0, `fifo_rst`=0. `cmd_start` → RESET.
- **RESET (1):** `fifo_rst`=1, `dec_rst`=1. Stays exactly `RST_CYCLES` cycles, then → WAIT_BUSY.
- **WAIT_BUSY (2):** `fifo_rst`=0, `dec_rst`=1. → PREFILL on the first cycle with `fifo_rst_busy`=0.
- **PREFILL (3):** `dec_rst`=0, `dec_en`=0. → RUN when `fifo_rd_count` ≥ `PREFILL` (unsigned compare).
- **RUN (4):** `dec_en`=1.
  - The starvation counter increments on each cycle with `dec_fifo_empty`=1 and clears on any cycle with it at 0.
  - On the `STARVE_CYCLES`-th consecutive empty cycle → STARVE. On that transition, set `intr_cause[0]` and increment `underrun_cnt`.
  - `dec_invalid`=1 → ERROR and set `intr_cause[1]`. Error takes priority over starvation in the same cycle.
- **STARVE (5):** `dec_en`=0, `dec_rst`=0; decoder state is preserved. → RUN when `fifo_rd_count` ≥ `PREFILL`. The counter is cleared on entry to RUN.
- **ERROR (6):** `dec_en`=0, `dec_rst`=1. `cmd_start` → RESET.

Commands apply in any state. Priority is `cmd_stop` > `cmd_flush` > `cmd_start`.
- `cmd_stop` → IDLE from any state.
- `cmd_flush` → RESET from any state except IDLE; it is ignored in IDLE.
- `cmd_start` is ignored outside IDLE and ERROR.

Interrupt:
- `intr_cause` bits are sticky.
- `intr_clr` clears both bits.
- A set in the same cycle as `intr_clr` wins.

## Timing
- **Reset values:** `state`=0, `fifo_rst`=0, `dec_rst`=1, `dec_en`=0, `intr_cause`=0, `intr`=0, `underrun_cnt`=0, internal counters=0.
- **Command latency:** a command sampled at edge N changes `state` and outputs after edge N (one cycle).
- **RESET entry:** `fifo_rst` rises the cycle after the command and stays high `RST_CYCLES` cycles. A flush issued during RESET restarts the count.
- **Prefill gate:** `dec_en` rises one cycle after the `fifo_rd_count` ≥ `PREFILL` sample. With `PREFILL`=0, PREFILL lasts one cycle.
- **Starvation:** `dec_en` falls one cycle after the `STARVE_CYCLES`-th consecutive empty sample. `intr` rises in the same cycle.
- **Saturation:** `underrun_cnt` holds at 0xFFFF and does not wrap.
- **Mid-operation reset:** `Rst` asserted at any time forces the reset values asynchronously.

## Configuration
- **`MP3DEC_SEQ_STARVE_EN` defined:** starvation detection, the STARVE state and `underrun_cnt` operate as described above.
- **`MP3DEC_SEQ_STARVE_EN` undefined:**
  - RUN leaves only on stop, flush or error.
  - The starvation counter is removed.
  - `intr_cause[0]` and `underrun_cnt` are tied to 0.
  - `STARVE_CYCLES` and `STARVE_W` are unused.

## Test plan
- **Bring-up:** `cmd_start` with `fifo_rst_busy` high for 5 cycles after RESET, then `fifo_rd_count` ramps 0→300 → `fifo_rst` high 8 cycles; WAIT_BUSY for 5 cycles; `dec_en`=1 one cycle after the count reaches 256.
- **Starvation:** in RUN, hold `dec_fifo_empty`=1 for 4095 cycles, drop it for 1 cycle, then hold for 4096 cycles → no STARVE after the first run; STARVE, `intr`=1 and `underrun_cnt`=1 after the second; `dec_en` returns 1 when the count reaches 256.
- **Error:** `dec_invalid` and a starvation threshold in the same cycle → ERROR, `intr_cause`=2'b10, `underrun_cnt` unchanged, `dec_rst`=1. Then `cmd_start` → RESET.
- **Command priority:** `cmd_stop`+`cmd_flush` together in RUN → IDLE. `cmd_flush` in IDLE → no change. `cmd_flush` at RESET cycle 5 → 8 further `fifo_rst` cycles.
- **Interrupt race:** `intr_clr` coincident with a new starvation event → `intr_cause[0]` remains 1. A subsequent `intr_clr` alone → `intr`=0.
- **Async reset:** `Rst` pulsed mid-RUN between clock edges → outputs immediately take their reset values; operation restarts only on a new `cmd_start`.
